// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S PMOD DAC source scheduler: scheduler
// states, channel indices and the default sample width.
package i2s_pkg;

    localparam int DATA_W_DEFAULT = 32;

    // Channel indices into the two-bit valid/ready vectors
    localparam int CH_L = 0;
    localparam int CH_R = 1;

    typedef enum logic [1:0] {
        PASS,
        FADE_OUT,
        SWAP,
        FADE_IN
    } sched_state_t;

endpackage

// File: rtl/i2s_gain_reg.sv
// One channel of the scheduler output stage: a single holding register
// loaded with (sample * gain) >>> GAIN_W, with valid/ready handshaking
// toward the DAC. The input side is ready whenever the register is empty
// or is being drained in the same cycle.
module i2s_gain_reg
    import i2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int GAIN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GAIN_W:0]   gain,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int PROD_W = DATA_W + GAIN_W + 2;

    logic signed [PROD_W-1:0] product;

    // Sample is sign-extended and gain zero-extended so the multiply is signed
    // and the shift below is arithmetic; truncation to DATA_W happens on load.
    assign product  = $signed({{(GAIN_W+2){in_data[DATA_W-1]}}, in_data})
                    * $signed({{(DATA_W+1){1'b0}}, gain});
    assign in_ready = ~out_valid | out_ready;

    // Hold register: load on an input transfer, empty once the DAC takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= DATA_W'(product >>> GAIN_W);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/i2s_src_sched.sv
// Source scheduler for the I2S PMOD DAC path. Routes one of two stereo
// sources to the DAC and, when the requested source changes, fades the
// gain down frame by frame, swaps sources between frames, and fades back up.
// The non-routed source is always accepted and discarded so neither stalls.
module i2s_src_sched
    import i2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int GAIN_W = 8,
    parameter int STEP   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic [DATA_W-1:0] s0_l_tdata,
    input  logic [DATA_W-1:0] s0_r_tdata,
    input  logic [1:0]        s0_tvalid,
    output logic [1:0]        s0_tready,
    input  logic [DATA_W-1:0] s1_l_tdata,
    input  logic [DATA_W-1:0] s1_r_tdata,
    input  logic [1:0]        s1_tvalid,
    output logic [1:0]        s1_tready,
    output logic [DATA_W-1:0] dac_l_tdata,
    output logic [DATA_W-1:0] dac_r_tdata,
    output logic [1:0]        dac_tvalid,
    input  logic [1:0]        dac_tready,
    output logic              active_src,
    output logic              busy,
    output logic [GAIN_W:0]   gain
);

    localparam logic [GAIN_W:0] UNITY  = {1'b1, {GAIN_W{1'b0}}};
    localparam logic [GAIN_W:0] STEP_G = (GAIN_W+1)'(STEP);

    sched_state_t      state_q, state_d;
    logic [GAIN_W:0]   gain_q, gain_d;
    logic              active_q, active_d;
    logic [1:0]        seen_q;
    logic [1:0]        dac_xfer;
    logic              frame_end;
    logic [1:0]        route_valid;
    logic [1:0]        route_ready;
    logic [DATA_W-1:0] route_l, route_r;
    logic [GAIN_W+1:0] gain_sum;

    assign route_valid = active_q ? s1_tvalid  : s0_tvalid;
    assign route_l     = active_q ? s1_l_tdata : s0_l_tdata;
    assign route_r     = active_q ? s1_r_tdata : s0_r_tdata;
    assign s0_tready   = active_q ? 2'b11 : route_ready;
    assign s1_tready   = active_q ? route_ready : 2'b11;

    assign dac_xfer  = dac_tvalid & dac_tready;
    assign frame_end = (seen_q[CH_L] | dac_xfer[CH_L]) & (seen_q[CH_R] | dac_xfer[CH_R]);
    assign gain_sum  = {1'b0, gain_q} + {1'b0, STEP_G};

    assign active_src = active_q;
    assign busy       = (state_q != PASS);
    assign gain       = gain_q;

    i2s_gain_reg #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) u_gain_l (
        .clk       (clk),
        .rst       (rst),
        .gain      (gain_q),
        .in_data   (route_l),
        .in_valid  (route_valid[CH_L]),
        .in_ready  (route_ready[CH_L]),
        .out_data  (dac_l_tdata),
        .out_valid (dac_tvalid[CH_L]),
        .out_ready (dac_tready[CH_L])
    );

    i2s_gain_reg #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) u_gain_r (
        .clk       (clk),
        .rst       (rst),
        .gain      (gain_q),
        .in_data   (route_r),
        .in_valid  (route_valid[CH_R]),
        .in_ready  (route_ready[CH_R]),
        .out_data  (dac_r_tdata),
        .out_valid (dac_tvalid[CH_R]),
        .out_ready (dac_tready[CH_R])
    );

    // Sticky per-channel DAC transfer flags; both clear when the frame completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q <= 2'b00;
        end else if (frame_end) begin
            seen_q <= 2'b00;
        end else begin
            seen_q <= seen_q | dac_xfer;
        end
    end

    // Scheduler state, gain and routed-source registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= PASS;
            gain_q   <= UNITY;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gain_q   <= gain_d;
            active_q <= active_d;
        end
    end

    // Next-state logic: request changes act immediately, gain moves only at frame end
    always_comb begin
        state_d  = state_q;
        gain_d   = gain_q;
        active_d = active_q;
        unique case (state_q)
            PASS: begin
                gain_d = UNITY;
                if (sel != active_q) begin
                    state_d = FADE_OUT;
                end
            end
            FADE_OUT: begin
                if (sel == active_q) begin
                    state_d = FADE_IN;
                end else if (frame_end) begin
                    if (gain_q <= STEP_G) begin
                        gain_d  = '0;
                        state_d = SWAP;
                    end else begin
                        gain_d = gain_q - STEP_G;
                    end
                end
            end
            SWAP: begin
                active_d = ~active_q;
                state_d  = FADE_IN;
            end
            FADE_IN: begin
                if (sel != active_q) begin
                    state_d = FADE_OUT;
                end else if (frame_end) begin
                    if (gain_sum >= {1'b0, UNITY}) begin
                        gain_d  = UNITY;
                        state_d = PASS;
                    end else begin
                        gain_d = gain_sum[GAIN_W:0];
                    end
                end
            end
            default: begin
                state_d = PASS;
            end
        endcase
    end

endmodule

// File: tb/tb_i2s_src_sched.sv
// Directed testbench for i2s_src_sched with GAIN_W=8, STEP=64: passthrough,
// full source swap, fade reversal, DAC back-pressure, extreme sample values
// and reset in the middle of a fade. Expected values are hand-computed.
module tb_i2s_src_sched;

    localparam int DATA_W = 32;
    localparam int GAIN_W = 8;
    localparam int STEP   = 64;

    logic              clk;
    logic              rst;
    logic              sel;
    logic [DATA_W-1:0] s0_l_tdata, s0_r_tdata;
    logic [1:0]        s0_tvalid, s0_tready;
    logic [DATA_W-1:0] s1_l_tdata, s1_r_tdata;
    logic [1:0]        s1_tvalid, s1_tready;
    logic [DATA_W-1:0] dac_l_tdata, dac_r_tdata;
    logic [1:0]        dac_tvalid, dac_tready;
    logic              active_src;
    logic              busy;
    logic [GAIN_W:0]   gain;

    int checkCount = 0;
    int failCount  = 0;

    i2s_src_sched #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .STEP(STEP)) dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .s0_l_tdata  (s0_l_tdata),
        .s0_r_tdata  (s0_r_tdata),
        .s0_tvalid   (s0_tvalid),
        .s0_tready   (s0_tready),
        .s1_l_tdata  (s1_l_tdata),
        .s1_r_tdata  (s1_r_tdata),
        .s1_tvalid   (s1_tvalid),
        .s1_tready   (s1_tready),
        .dac_l_tdata (dac_l_tdata),
        .dac_r_tdata (dac_r_tdata),
        .dac_tvalid  (dac_tvalid),
        .dac_tready  (dac_tready),
        .active_src  (active_src),
        .busy        (busy),
        .gain        (gain)
    );

    // Free-running clock, active edge is posedge
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] a_l, input logic [DATA_W-1:0] a_r,
                                 input logic [DATA_W-1:0] b_l, input logic [DATA_W-1:0] b_r);
        s0_l_tdata = a_l;
        s0_r_tdata = a_r;
        s1_l_tdata = b_l;
        s1_r_tdata = b_r;
    endtask

    // One stereo frame with dac_tready high: load on the first edge, DAC
    // transfer and frame end on the second. Entered and left at a negedge.
    task automatic runFrame(input string tag, input logic [31:0] exp_l, input logic [31:0] exp_r,
                            input logic [31:0] exp_gain);
        s0_tvalid = 2'b11;
        s1_tvalid = 2'b11;
        @(negedge clk);
        s0_tvalid = 2'b00;
        s1_tvalid = 2'b00;
        checkOutput({tag, "_vld"}, 32'(dac_tvalid), 32'd3);
        checkOutput({tag, "_l"}, dac_l_tdata, exp_l);
        checkOutput({tag, "_r"}, dac_r_tdata, exp_r);
        @(negedge clk);
        checkOutput({tag, "_gain"}, 32'(gain), exp_gain);
    endtask

    initial begin
        rst        = 1'b1;
        sel        = 1'b0;
        s0_tvalid  = 2'b00;
        s1_tvalid  = 2'b00;
        dac_tready = 2'b11;
        applyStimulus(32'd0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("rst_gain", 32'(gain), 32'd256);
        checkOutput("rst_active", 32'(active_src), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_vld", 32'(dac_tvalid), 32'd0);
        checkOutput("rst_l", dac_l_tdata, 32'd0);

        // Passthrough from source 0
        applyStimulus(1000, -1000, 2000, -2000);
        #1;
        checkOutput("pass_s0rdy", 32'(s0_tready), 32'd3);
        checkOutput("pass_s1rdy", 32'(s1_tready), 32'd3);
        @(negedge clk);
        runFrame("pass0", 1000, -1000, 256);
        checkOutput("pass0_busy", 32'(busy), 32'd0);

        // Full swap 0 -> 1
        sel = 1'b1;
        runFrame("fo1", 1000, -1000, 192);
        checkOutput("fo1_busy", 32'(busy), 32'd1);
        runFrame("fo2", 750, -750, 128);
        runFrame("fo3", 500, -500, 64);
        runFrame("fo4", 250, -250, 0);
        checkOutput("swap_active_pre", 32'(active_src), 32'd0);
        runFrame("swp", 0, 0, 64);
        checkOutput("swap_active_post", 32'(active_src), 32'd1);
        checkOutput("swap_s0rdy", 32'(s0_tready), 32'd3);
        runFrame("fi2", 500, -500, 128);
        runFrame("fi3", 1000, -1000, 192);
        runFrame("fi4", 1500, -1500, 256);
        checkOutput("fi4_busy", 32'(busy), 32'd0);
        runFrame("pass1", 2000, -2000, 256);

        // Reversal: request changes back mid-fade
        sel = 1'b0;
        runFrame("rv1", 2000, -2000, 192);
        runFrame("rv2", 1500, -1500, 128);
        sel = 1'b1;
        runFrame("rv3", 1000, -1000, 192);
        runFrame("rv4", 1500, -1500, 256);
        checkOutput("rv_busy", 32'(busy), 32'd0);
        checkOutput("rv_active", 32'(active_src), 32'd1);

        // DAC stall during a fade
        sel = 1'b0;
        runFrame("st0", 2000, -2000, 192);
        s1_tvalid  = 2'b11;
        dac_tready = 2'b00;
        @(negedge clk);
        s1_tvalid = 2'b00;
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_vld", 32'(dac_tvalid), 32'd3);
            checkOutput("stall_l", dac_l_tdata, 32'd1500);
            checkOutput("stall_r", dac_r_tdata, -1500);
            checkOutput("stall_gain", 32'(gain), 32'd192);
            checkOutput("stall_s1rdy", 32'(s1_tready), 32'd0);
            @(negedge clk);
        end
        checkOutput("stall_s0rdy", 32'(s0_tready), 32'd3);
        dac_tready = 2'b11;
        @(negedge clk);
        checkOutput("stall_rel_gain", 32'(gain), 32'd128);
        checkOutput("stall_rel_vld", 32'(dac_tvalid), 32'd0);

        // Extreme samples through source 1, then swap to source 0
        applyStimulus(1000, -1000, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        runFrame("mx1", 32'h3FFF_FFFF, 32'hFFFF_FFFF, 64);
        applyStimulus(1000, -1000, 32'h7FFF_FFFF, 32'h8000_0000);
        runFrame("mx2", 32'h1FFF_FFFF, 32'hE000_0000, 0);
        runFrame("swp2", 0, 0, 64);
        checkOutput("swp2_active", 32'(active_src), 32'd0);
        runFrame("fi_s0", 250, -250, 128);

        // Reset while fading out with both output registers full
        sel        = 1'b1;
        s0_tvalid  = 2'b11;
        dac_tready = 2'b00;
        @(negedge clk);
        s0_tvalid = 2'b00;
        checkOutput("prerst_busy", 32'(busy), 32'd1);
        checkOutput("prerst_vld", 32'(dac_tvalid), 32'd3);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_vld", 32'(dac_tvalid), 32'd0);
        checkOutput("arst_l", dac_l_tdata, 32'd0);
        checkOutput("arst_r", dac_r_tdata, 32'd0);
        checkOutput("arst_gain", 32'(gain), 32'd256);
        checkOutput("arst_active", 32'(active_src), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        sel        = 1'b0;
        dac_tready = 2'b11;
        rst        = 1'b0;
        @(negedge clk);
        checkOutput("postrst_busy", 32'(busy), 32'd0);
        checkOutput("postrst_gain", 32'(gain), 32'd256);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
